uart_tx_serializer: RTL and testbench

Serial UART transmitter feeding the board's TX pin. It accepts one byte per `new_data` strobe over the same `data`/`new_data`/`busy` handshake that message and echo logic drive. It frames each byte as start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits, each bit lasting `CLK_PER_BIT` clocks. A `block` input provides flow control: while it is high, no new frame starts.

---
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter with optional parity, 1 or 2
// stop bits and a flow-control hold. tx and busy are both registered.
module uart_tx_serializer #(
   parameter int unsigned CLK_PER_BIT = 50,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       new_data,
   input  logic       block,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       shift;
   logic [2:0]       idx;
   logic             par_acc;
   logic             stop_idx;
   logic             bit_end;
   logic             par_bit;

   // Last clock of the current bit period.
   assign bit_end = (cnt == CNT_LAST);

   // Parity over all eight bits; shift[0] holds data[7] during the last data bit.
   assign par_bit = par_acc ^ shift[0] ^ PAR_ODD;

   // Frame sequencer: baud counter, bit shifting and registered tx/busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shift    <= '0;
         idx      <= '0;
         par_acc  <= 1'b0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (new_data && !block) begin
                  shift    <= data;
                  par_acc  <= 1'b0;
                  idx      <= '0;
                  stop_idx <= 1'b0;
                  state    <= START;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  tx   <= 1'b1;
                  busy <= block;
               end
            end
            START: begin
               busy <= 1'b1;
               if (bit_end) begin
                  cnt   <= '0;
                  state <= DATA;
                  tx    <= shift[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               busy <= 1'b1;
               if (bit_end) begin
                  cnt     <= '0;
                  par_acc <= par_acc ^ shift[0];
                  shift   <= shift >> 1;
                  if (idx == 3'd7) begin
                     if (PARITY != 0) begin
                        state <= PAR;
                        tx    <= par_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                     tx  <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PAR: begin
               busy <= 1'b1;
               if (bit_end) begin
                  cnt   <= '0;
                  state <= STOP;
                  tx    <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  cnt <= '0;
                  if (stop_idx == STOP_LAST) begin
                     state <= IDLE;
                     busy  <= block;
                  end else begin
                     stop_idx <= 1'b1;
                     busy     <= 1'b1;
                  end
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  busy <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= block;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three transmitter configurations driven in parallel
// and compared cycle by cycle with a frame-level reference model.
module tb_uart_tx_serializer;

   localparam int CPB = 4;
   localparam int NI  = 3;
   // Instance configs: 0 = no parity/1 stop, 1 = even/1 stop, 2 = odd/2 stop.
   localparam int PAR_CFG [NI] = '{0, 2, 1};
   localparam int STP_CFG [NI] = '{1, 1, 2};

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       new_data;
   logic       block;
   logic [2:0] txv;
   logic [2:0] bsv;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int         rem [NI];
   logic [7:0] md  [NI];
   logic       mbusy [NI];

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLK_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_p0 (
      .clk(clk), .rst(rst), .data(data), .new_data(new_data), .block(block),
      .tx(txv[0]), .busy(bsv[0]));
   uart_tx_serializer #(.CLK_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_pe (
      .clk(clk), .rst(rst), .data(data), .new_data(new_data), .block(block),
      .tx(txv[1]), .busy(bsv[1]));
   uart_tx_serializer #(.CLK_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_po (
      .clk(clk), .rst(rst), .data(data), .new_data(new_data), .block(block),
      .tx(txv[2]), .busy(bsv[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int flen(input int i);
      return (1 + 8 + ((PAR_CFG[i] != 0) ? 1 : 0) + STP_CFG[i]) * CPB;
   endfunction

   // Line level at a given cycle offset into a frame of byte d.
   function automatic logic exp_line(input int i, input logic [7:0] d, input int pos);
      int b;
      b = pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (PAR_CFG[i] != 0 && b == 9) return (^d) ^ (PAR_CFG[i] == 1);
      return 1'b1;
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      logic       r_s, nd_s, bl_s;
      logic [7:0] d_s;
      logic       idle;
      r_s = rst; nd_s = new_data; bl_s = block; d_s = data;
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         if (r_s) begin
            rem[i]   = 0;
            mbusy[i] = 1'b0;
         end else begin
            idle = (rem[i] == 0);
            if (rem[i] > 0) rem[i]--;
            if (idle && nd_s && !bl_s) begin
               rem[i] = flen(i);
               md[i]  = d_s;
            end
            mbusy[i] = (rem[i] > 0) || bl_s;
         end
      end
      #1;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("tx[%0d]", i), 32'(txv[i]),
             32'((rem[i] == 0) ? 1'b1 : exp_line(i, md[i], flen(i) - rem[i])));
         chk($sformatf("busy[%0d]", i), 32'(bsv[i]), 32'(mbusy[i]));
      end
   endtask

   task automatic send(input logic [7:0] d);
      data     = d;
      new_data = 1'b1;
      step();
      new_data = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && n < 200) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(n >= 200), 32'd0);
   endtask

   initial begin
      int cnt_a, cnt_b, cnt_c;
      for (int i = 0; i < NI; i++) begin
         rem[i] = 0; md[i] = 8'h00; mbusy[i] = 1'b0;
      end
      rst = 1'b1; data = 8'h00; new_data = 1'b0; block = 1'b0;
      step();
      step();
      chk("rst_tx", 32'(txv), 32'h7);
      chk("rst_busy", 32'(bsv), 32'h0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("idle_tx", 32'(txv), 32'h7);

      // 0x55 without parity: alternating line, 40 busy cycles.
      send(8'h55);
      cnt_a = int'(bsv[0]);
      for (int j = 1; j < 60; j++) begin
         if (j < 40 && (j % CPB) == 2) chk("p0_55_bit", 32'(txv[0]), 32'((j / CPB) % 2));
         step();
         cnt_a += int'(bsv[0]);
      end
      chk("p0_busy_len", 32'(cnt_a), 32'd40);

      // 0x07: even parity bit 1, odd parity bit 0.
      send(8'h07);
      cnt_b = int'(bsv[1]);
      cnt_c = int'(bsv[2]);
      for (int j = 1; j < 60; j++) begin
         step();
         if (j == 9 * CPB + 1) begin
            chk("even_par", 32'(txv[1]), 32'd1);
            chk("odd_par", 32'(txv[2]), 32'd0);
         end
         cnt_b += int'(bsv[1]);
         cnt_c += int'(bsv[2]);
      end
      chk("even_busy_len", 32'(cnt_b), 32'd44);
      chk("odd2_busy_len", 32'(cnt_c), 32'd48);

      // Stray 0xFF strobe inside a 0x00 frame is dropped.
      send(8'h00);
      for (int j = 1; j < 12; j++) step();
      send(8'hFF);
      wait_idle();
      for (int j = 0; j < 5; j++) step();
      chk("no_second_frame", 32'(bsv), 32'h0);

      // Block holds off a strobe; the byte goes once block drops.
      block = 1'b1;
      step();
      send(8'hA5);
      chk("blocked_tx", 32'(txv), 32'h7);
      chk("blocked_busy", 32'(bsv), 32'h7);
      block = 1'b0;
      step();
      chk("unblocked_busy", 32'(bsv), 32'h0);
      send(8'hA5);
      chk("a5_start", 32'(txv), 32'h0);
      wait_idle();

      // Reset mid-frame aborts, then a clean frame follows.
      send(8'h96);
      for (int j = 1; j < 20; j++) step();
      rst = 1'b1;
      step();
      chk("midrst_tx", 32'(txv), 32'h7);
      chk("midrst_busy", 32'(bsv), 32'h0);
      rst = 1'b0;
      send(8'h3C);
      wait_idle();
      step();

      // Randomized frames with stray strobes and block activity.
      for (int f = 0; f < 25; f++) begin
         block = ($urandom_range(0, 3) == 0);
         send(8'($urandom));
         block = 1'b0;
         for (int j = 0; j < 60; j++) begin
            data     = 8'($urandom);
            new_data = ($urandom_range(0, 15) == 0);
            block    = ($urandom_range(0, 7) == 0);
            step();
         end
         new_data = 1'b0;
         block    = 1'b0;
         wait_idle();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
